disp_region_mux: RTL and testbench

- Parametrised pixel-source compositor between the render modules (character/background, map, future layers) and lcd_driver.
- Replaces the fixed "upper half = background, lower half = map" split with a table of NUM_REGION horizontal bands.
- Each band selects one of NUM_SRC pixel sources.
- Band configuration is double-buffered: the MCU/control side writes a shadow table, and it takes effect only at the next frame start, so the screen never tears mid-frame.

---
 rtl/disp_region_mux_if.sv | 38 +++
 rtl/disp_region_mux.sv | 123 ++++++++++++
 tb/tb_disp_region_mux.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/disp_region_mux_if.sv
// Pixel and configuration bus between lcd_driver/MCU side and disp_region_mux.
// The master side drives requests and config; the slave (compositor) drives pixels out.
interface disp_region_mux_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned PIX_W   = 16,
  parameter int unsigned COORD_W = 9,
  parameter int unsigned SRC_W   = 3,
  parameter int unsigned IDX_W   = 3
);
  logic [COORD_W-1:0]       pix_x;
  logic [COORD_W-1:0]       pix_y;
  logic                     pix_req;
  logic [NUM_SRC*PIX_W-1:0] src_data;
  logic [PIX_W-1:0]         bg_color;
  logic                     cfg_we;
  logic [IDX_W-1:0]         cfg_idx;
  logic [COORD_W-1:0]       cfg_y_start;
  logic [COORD_W-1:0]       cfg_y_end;
  logic [SRC_W-1:0]         cfg_src;
  logic                     cfg_en;
  logic                     cfg_commit;
  logic [PIX_W-1:0]         pix_out;
  logic                     pix_out_valid;
  logic                     frame_start;
  logic                     cfg_pending;

  modport master (
    output pix_x, pix_y, pix_req, src_data, bg_color,
    output cfg_we, cfg_idx, cfg_y_start, cfg_y_end, cfg_src, cfg_en, cfg_commit,
    input  pix_out, pix_out_valid, frame_start, cfg_pending
  );

  modport slave (
    input  pix_x, pix_y, pix_req, src_data, bg_color,
    input  cfg_we, cfg_idx, cfg_y_start, cfg_y_end, cfg_src, cfg_en, cfg_commit,
    output pix_out, pix_out_valid, frame_start, cfg_pending
  );
endinterface

// File: rtl/disp_region_mux.sv
// Band-based pixel-source compositor with a double-buffered region table.
// Shadow table is copied to the active table only when a frame-start pixel is accepted.
module disp_region_mux #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned NUM_REGION = 4,
  parameter int unsigned PIX_W      = 16,
  parameter int unsigned COORD_W    = 9,
  parameter int unsigned SRC_W      = 3,
  parameter int unsigned IDX_W      = 3
) (
  input logic               clk,
  input logic               rst,
  disp_region_mux_if.slave  bus
);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] y_start;
    logic [COORD_W-1:0] y_end;
    logic [SRC_W-1:0]   src;
  } entry_t;

  function automatic entry_t default_entry(input int unsigned i);
    entry_t e;
    e = '0;
    if (i == 0) begin
      e.en    = 1'b1;
      e.y_end = COORD_W'(239);
    end else if (i == 1) begin
      e.en      = 1'b1;
      e.y_start = COORD_W'(240);
      e.y_end   = '1;
      e.src     = SRC_W'(1);
    end
    return e;
  endfunction

  entry_t shadow_q [NUM_REGION];
  entry_t shadow_d [NUM_REGION];
  entry_t active_q [NUM_REGION];
  entry_t active_d [NUM_REGION];

  logic                     pending_q, pending_d;
  logic                     frame_px, swap;
  logic [NUM_REGION-1:0]    hit_d, hit_q;
  logic [NUM_SRC*PIX_W-1:0] data_q;
  logic                     v1_q, v2_q, frame_q;
  logic [PIX_W-1:0]         pix_q, pix_d;
  logic                     sel_hit;
  logic [SRC_W-1:0]         sel_src;

  // Table update and stage-1 hit detection; hits see the post-swap table.
  always_comb begin
    frame_px  = bus.pix_req && (bus.pix_x == '0) && (bus.pix_y == '0);
    swap      = frame_px && (pending_q || bus.cfg_commit);
    pending_d = swap ? 1'b0 : (pending_q | bus.cfg_commit);
    hit_d     = '0;
    for (int i = 0; i < int'(NUM_REGION); i++) begin
      shadow_d[i] = shadow_q[i];
      if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
        shadow_d[i] = '{en: bus.cfg_en, y_start: bus.cfg_y_start, y_end: bus.cfg_y_end,
                        src: bus.cfg_src};
      end
      active_d[i] = swap ? shadow_d[i] : active_q[i];
      hit_d[i]    = active_d[i].en && (active_d[i].y_start <= bus.pix_y) &&
                    (bus.pix_y <= active_d[i].y_end);
    end
  end

  // Stage 2: lowest-index hit wins; out-of-range source falls back to background.
  always_comb begin
    sel_hit = 1'b0;
    sel_src = '0;
    for (int i = int'(NUM_REGION) - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        sel_hit = 1'b1;
        sel_src = active_q[i].src;
      end
    end
    pix_d = bus.bg_color;
    if (sel_hit) begin
      for (int k = 0; k < int'(NUM_SRC); k++) begin
        if (sel_src == SRC_W'(k)) pix_d = data_q[k*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGION); i++) begin
        shadow_q[i] <= default_entry(i);
        active_q[i] <= default_entry(i);
      end
      pending_q <= 1'b0;
      hit_q     <= '0;
      data_q    <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      frame_q   <= 1'b0;
      pix_q     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGION); i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pending_q <= pending_d;
      v1_q      <= bus.pix_req;
      v2_q      <= v1_q;
      frame_q   <= frame_px;
      if (bus.pix_req) begin
        data_q <= bus.src_data;
        hit_q  <= hit_d;
      end
      if (v1_q) pix_q <= pix_d;
    end
  end

  assign bus.pix_out       = pix_q;
  assign bus.pix_out_valid = v2_q;
  assign bus.frame_start   = frame_q;
  assign bus.cfg_pending   = pending_q;

endmodule

// File: tb/tb_disp_region_mux.sv
// Scoreboard bench for disp_region_mux: stimulus pushes expected pixels, a monitor pops them.
module tb_disp_region_mux;

  localparam int unsigned NUM_SRC    = 4;
  localparam int unsigned NUM_REGION = 4;
  localparam int unsigned PIX_W      = 16;
  localparam int unsigned COORD_W    = 9;
  localparam int unsigned SRC_W      = 3;
  localparam int unsigned IDX_W      = 3;

  typedef struct {
    logic [15:0] v;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q [$];

  disp_region_mux_if #(
    .NUM_SRC (NUM_SRC),
    .PIX_W   (PIX_W),
    .COORD_W (COORD_W),
    .SRC_W   (SRC_W),
    .IDX_W   (IDX_W)
  ) bus ();

  disp_region_mux #(
    .NUM_SRC    (NUM_SRC),
    .NUM_REGION (NUM_REGION),
    .PIX_W      (PIX_W),
    .COORD_W    (COORD_W),
    .SRC_W      (SRC_W),
    .IDX_W      (IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid output must match the oldest expectation, exactly 2 cycles late.
  always @(negedge clk) begin
    if (bus.pix_out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got pix_out=%h at cycle %0d, required no output",
                 bus.pix_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.pix_out !== e.v || cyc != e.cyc) begin
          failures++;
          $display("FAIL pix_out: got %h at cycle %0d, required %h at cycle %0d",
                   bus.pix_out, cyc, e.v, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input logic [8:0] x, input logic [8:0] y, input logic [15:0] e);
    exp_t t;
    bus.pix_x   = x;
    bus.pix_y   = y;
    bus.pix_req = 1'b1;
    t.v   = e;
    t.cyc = cyc + 2;
    exp_q.push_back(t);
    @(negedge clk);
    bus.pix_req = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [8:0] ys, input logic [8:0] ye,
                           input logic [2:0] src, input logic en);
    bus.cfg_we      = 1'b1;
    bus.cfg_idx     = idx;
    bus.cfg_y_start = ys;
    bus.cfg_y_end   = ye;
    bus.cfg_src     = src;
    bus.cfg_en      = en;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    @(negedge clk);
    bus.cfg_commit = 1'b0;
  endtask

  initial begin
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    bus.pix_req     = 1'b0;
    bus.src_data    = {16'h001F, 16'h1234, 16'h07E0, 16'hF800};
    bus.bg_color    = 16'hAAAA;
    bus.cfg_we      = 1'b0;
    bus.cfg_idx     = '0;
    bus.cfg_y_start = '0;
    bus.cfg_y_end   = '0;
    bus.cfg_src     = '0;
    bus.cfg_en      = 1'b0;
    bus.cfg_commit  = 1'b0;
    idle(3);
    rst = 1'b0;

    chk("reset_pix_out", 32'(bus.pix_out), 32'h0);
    chk("reset_valid", 32'(bus.pix_out_valid), 32'h0);
    chk("reset_frame_start", 32'(bus.frame_start), 32'h0);
    chk("reset_pending", 32'(bus.cfg_pending), 32'h0);

    // Default split: rows 0..239 -> src0, 240.. -> src1.
    pix(9'd10, 9'd100, 16'hF800);
    pix(9'd10, 9'd300, 16'h07E0);
    pix(9'd10, 9'd239, 16'hF800);
    pix(9'd10, 9'd240, 16'h07E0);
    idle(3);

    // Shadow writes plus commit take effect only at frame start.
    cfg_write(3'd0, 9'd0, 9'd49, 3'd0, 1'b1);
    cfg_write(3'd2, 9'd50, 9'd60, 3'd3, 1'b1);
    chk("pending_before_commit", 32'(bus.cfg_pending), 32'h0);
    commit();
    chk("pending_after_commit", 32'(bus.cfg_pending), 32'h1);
    pix(9'd5, 9'd55, 16'hF800);
    chk("pending_held", 32'(bus.cfg_pending), 32'h1);
    pix(9'd0, 9'd0, 16'hF800);
    chk("frame_start_pulse", 32'(bus.frame_start), 32'h1);
    chk("pending_cleared", 32'(bus.cfg_pending), 32'h0);
    idle(1);
    chk("frame_start_one_cycle", 32'(bus.frame_start), 32'h0);
    pix(9'd5, 9'd55, 16'h001F);
    pix(9'd5, 9'd61, 16'hAAAA);
    pix(9'd5, 9'd250, 16'h07E0);
    // Post-swap shadow write without a commit must not reach the active table.
    cfg_write(3'd2, 9'd50, 9'd60, 3'd1, 1'b1);
    pix(9'd0, 9'd0, 16'hF800);
    pix(9'd5, 9'd55, 16'h001F);
    idle(3);

    // Disable entries 0 and 1; entry2 now picks up its shadowed src1.
    bus.bg_color = 16'hFFFF;
    cfg_write(3'd0, 9'd0, 9'd49, 3'd0, 1'b0);
    cfg_write(3'd1, 9'd240, 9'd511, 3'd1, 1'b0);
    commit();
    commit();
    pix(9'd0, 9'd0, 16'hFFFF);
    chk("pending_repeat_commit", 32'(bus.cfg_pending), 32'h0);
    pix(9'd3, 9'd10, 16'hFFFF);
    pix(9'd3, 9'd55, 16'h07E0);
    idle(3);

    // Inverted band never hits; out-of-range source gives background.
    cfg_write(3'd0, 9'd200, 9'd100, 3'd0, 1'b1);
    cfg_write(3'd2, 9'd50, 9'd60, 3'd3, 1'b0);
    cfg_write(3'd3, 9'd300, 9'd310, 3'd7, 1'b1);
    commit();
    pix(9'd0, 9'd0, 16'hFFFF);
    pix(9'd1, 9'd150, 16'hFFFF);
    pix(9'd1, 9'd100, 16'hFFFF);
    pix(9'd1, 9'd200, 16'hFFFF);
    pix(9'd1, 9'd305, 16'hFFFF);
    idle(3);

    // Write and commit in the same cycle as the frame-start pixel.
    bus.cfg_we      = 1'b1;
    bus.cfg_idx     = 3'd3;
    bus.cfg_y_start = 9'd300;
    bus.cfg_y_end   = 9'd310;
    bus.cfg_src     = 3'd2;
    bus.cfg_en      = 1'b1;
    bus.cfg_commit  = 1'b1;
    pix(9'd0, 9'd0, 16'hFFFF);
    bus.cfg_we     = 1'b0;
    bus.cfg_commit = 1'b0;
    chk("pending_same_cycle", 32'(bus.cfg_pending), 32'h0);
    pix(9'd1, 9'd305, 16'h1234);
    idle(3);

    // Out-of-range index write is dropped; then a back-to-back stream of 320 pixels.
    cfg_write(3'd5, 9'd0, 9'd511, 3'd3, 1'b1);
    commit();
    for (int i = 0; i < 320; i++) begin
      pix(9'(i), 9'(i), (i >= 300 && i <= 310) ? 16'h1234 : 16'hFFFF);
    end
    idle(4);
    chk("pix_out_hold", 32'(bus.pix_out), 32'hFFFF);
    chk("stream_drained", 32'(exp_q.size()), 32'h0);

    // Reset with a pixel in flight: no output, defaults restored.
    commit();
    chk("pending_before_rst", 32'(bus.cfg_pending), 32'h1);
    bus.pix_x   = 9'd2;
    bus.pix_y   = 9'd100;
    bus.pix_req = 1'b1;
    @(negedge clk);
    bus.pix_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("no_valid_after_rst", 32'(bus.pix_out_valid), 32'h0);
      idle(1);
    end
    chk("rst_pending", 32'(bus.cfg_pending), 32'h0);
    chk("rst_pix_out", 32'(bus.pix_out), 32'h0);
    pix(9'd2, 9'd100, 16'hF800);
    pix(9'd2, 9'd300, 16'h07E0);
    pix(9'd2, 9'd55, 16'hF800);
    pix(9'd2, 9'd511, 16'h07E0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    chk("final_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
